// File: rtl/rs_int_pkg.sv
// Shared types for the integer reservation station: dispatch, wakeup, PRF read and issue packets.
package rs_int_pkg;

  localparam int RS_INT_NUM_ENTRIES = 8;
  localparam int PRF_ID_W           = 6;
  localparam int ROB_ID_W           = 6;
  localparam int XLEN               = 32;

  typedef logic [PRF_ID_W-1:0] t_prf_id;
  typedef logic [ROB_ID_W-1:0] t_rob_id;
  typedef logic [XLEN-1:0]     t_rv_reg_data;

  typedef enum logic [1:0] {
    OP_ZERO = 2'd0,
    OP_REG  = 2'd1,
    OP_IMM  = 2'd2
  } t_optype;

  typedef struct packed {
    t_optype    optype;
    logic [4:0] areg;
  } t_src;

  typedef struct packed {
    logic [6:0]  opcode;
    t_src        src1;
    t_src        src2;
    logic [11:0] imm;
  } t_uinstr;

  typedef struct packed {
    logic    valid;
    t_rob_id robid;
  } t_nuke_pkt;

  typedef struct packed {
    t_uinstr uinstr;
    t_rob_id robid;
    t_prf_id pdst;
    t_prf_id psrc1;
    t_prf_id psrc2;
  } t_rs_disp_pkt;

  typedef struct packed {
    t_prf_id      pdst;
    t_rv_reg_data data;
  } t_prf_wr_pkt;

  typedef struct packed {
    t_uinstr      uinstr;
    t_rob_id      robid;
    t_prf_id      pdst;
    t_rv_reg_data src1_val;
    t_rv_reg_data src2_val;
  } t_iss_pkt;

  typedef struct packed {
    logic    valid;
    t_uinstr uinstr;
    t_rob_id robid;
    t_prf_id pdst;
    t_prf_id psrc1;
    t_prf_id psrc2;
    logic    rdy1;
    logic    rdy2;
  } t_rs_entry;

  function automatic logic src_is_reg(t_src s);
    return s.optype == OP_REG;
  endfunction

endpackage

// File: rtl/rs_int_if.sv
// Bundle between dispatch/execute/PRF and the integer RS; master is the RS side.
interface rs_int_if;
  import rs_int_pkg::*;

  t_nuke_pkt    nuke_rb1;
  logic         disp_valid_rs0;
  t_rs_disp_pkt disp_pkt_rs0;
  logic         rs_full_rs0;
  logic         iprf_wr_en_ex1;
  t_prf_wr_pkt  iprf_wr_pkt_ex1;
  logic         prf_rd_en_rs0;
  t_prf_id      prf_rd_psrc1_rs0;
  t_prf_id      prf_rd_psrc2_rs0;
  t_rv_reg_data prf_rd_data1_rs1;
  t_rv_reg_data prf_rd_data2_rs1;
  logic         iss_ex0;
  t_iss_pkt     iss_pkt_ex0;

  modport master (
    input  nuke_rb1, disp_valid_rs0, disp_pkt_rs0, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
    input  prf_rd_data1_rs1, prf_rd_data2_rs1,
    output rs_full_rs0, prf_rd_en_rs0, prf_rd_psrc1_rs0, prf_rd_psrc2_rs0,
    output iss_ex0, iss_pkt_ex0
  );

  modport slave (
    output nuke_rb1, disp_valid_rs0, disp_pkt_rs0, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
    output prf_rd_data1_rs1, prf_rd_data2_rs1,
    input  rs_full_rs0, prf_rd_en_rs0, prf_rd_psrc1_rs0, prf_rd_psrc2_rs0,
    input  iss_ex0, iss_pkt_ex0
  );

endinterface

// File: rtl/rs_int_age_matrix.sv
// Age matrix for oldest-ready select; only instantiated when RS_INT_AGE_SELECT_EN is defined.
module rs_age_matrix #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] valid_vec,
  input  logic [NUM_ENTRIES-1:0] disp_vec,
  input  logic [NUM_ENTRIES-1:0] ready_vec,
  output logic [NUM_ENTRIES-1:0] oldest_oh
);

  // older_vec[i][j] = 1 means entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_vec;

  genvar gi;
  for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_row
    logic [NUM_ENTRIES-1:0] row_reg;
    logic                   blocked;

    always_ff @(posedge clk) begin
      if (reset) begin
        row_reg <= '0;
      end else if (disp_vec[gi]) begin
        row_reg <= '0;
      end else begin
        row_reg <= (row_reg & ~disp_vec) | (disp_vec & {NUM_ENTRIES{valid_vec[gi]}});
      end
    end

    assign older_vec[gi] = row_reg;

    always_comb begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (ready_vec[j] && older_vec[j][gi]) blocked = 1'b1;
      end
    end

    assign oldest_oh[gi] = ready_vec[gi] & ~blocked;
  end

endmodule

// File: rtl/rs_int.sv
// Integer reservation station: dispatch, wakeup, single select per cycle, PRF read, issue to EX0.
// Define RS_INT_AGE_SELECT_EN for oldest-ready select; default is lowest-index ready select.
module rs_int
  import rs_int_pkg::*;
#(
  parameter int NUM_ENTRIES = RS_INT_NUM_ENTRIES,
  parameter int ENTRY_IDX_W = $clog2(NUM_ENTRIES)
) (
  input logic      clk,
  input logic      reset,
  rs_int_if.master rs
);

  t_rs_entry [NUM_ENTRIES-1:0] ent_vec;
  logic [NUM_ENTRIES-1:0] valid_vec, ready_vec, free_vec, alloc_oh, alloc_vec, sel_oh;
  logic [ENTRY_IDX_W-1:0] sel_idx;
  logic                   sel_valid, disp_fire, disp_rdy1, disp_rdy2;
  t_rs_entry              sel_entry;

  logic    rs1_valid_reg, rs1_valid_next;
  t_uinstr rs1_uinstr_reg;
  t_rob_id rs1_robid_reg;
  t_prf_id rs1_pdst_reg;

  assign rs.rs_full_rs0 = &valid_vec;
  assign disp_fire = rs.disp_valid_rs0 & ~rs.rs_full_rs0 & ~rs.nuke_rb1.valid;

  // Free vector comes from registered state, so an entry selected this cycle is never reused
  assign free_vec  = ~valid_vec;
  assign alloc_oh  = free_vec & (~free_vec + NUM_ENTRIES'(1));
  assign alloc_vec = disp_fire ? alloc_oh : '0;

  assign disp_rdy1 = ~src_is_reg(rs.disp_pkt_rs0.uinstr.src1) ||
                     (rs.iprf_wr_en_ex1 && rs.iprf_wr_pkt_ex1.pdst == rs.disp_pkt_rs0.psrc1);
  assign disp_rdy2 = ~src_is_reg(rs.disp_pkt_rs0.uinstr.src2) ||
                     (rs.iprf_wr_en_ex1 && rs.iprf_wr_pkt_ex1.pdst == rs.disp_pkt_rs0.psrc2);

  genvar gi;
  for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ent
    t_rs_entry ent_reg;
    logic      wake1, wake2;

    assign wake1 = rs.iprf_wr_en_ex1 && ent_reg.valid && src_is_reg(ent_reg.uinstr.src1) &&
                   (ent_reg.psrc1 == rs.iprf_wr_pkt_ex1.pdst);
    assign wake2 = rs.iprf_wr_en_ex1 && ent_reg.valid && src_is_reg(ent_reg.uinstr.src2) &&
                   (ent_reg.psrc2 == rs.iprf_wr_pkt_ex1.pdst);

    always_ff @(posedge clk) begin
      if (reset) begin
        ent_reg <= '0;
      end else if (rs.nuke_rb1.valid) begin
        ent_reg.valid <= 1'b0;
      end else if (alloc_vec[gi]) begin
        ent_reg.valid  <= 1'b1;
        ent_reg.uinstr <= rs.disp_pkt_rs0.uinstr;
        ent_reg.robid  <= rs.disp_pkt_rs0.robid;
        ent_reg.pdst   <= rs.disp_pkt_rs0.pdst;
        ent_reg.psrc1  <= rs.disp_pkt_rs0.psrc1;
        ent_reg.psrc2  <= rs.disp_pkt_rs0.psrc2;
        ent_reg.rdy1   <= disp_rdy1;
        ent_reg.rdy2   <= disp_rdy2;
      end else begin
        if (sel_oh[gi]) ent_reg.valid <= 1'b0;
        if (wake1)      ent_reg.rdy1  <= 1'b1;
        if (wake2)      ent_reg.rdy2  <= 1'b1;
      end
    end

    assign ent_vec[gi]   = ent_reg;
    assign valid_vec[gi] = ent_reg.valid;
    assign ready_vec[gi] = ent_reg.valid & ent_reg.rdy1 & ent_reg.rdy2;
  end

`ifdef RS_INT_AGE_SELECT_EN
  rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
    .clk       (clk),
    .reset     (reset),
    .valid_vec (valid_vec),
    .disp_vec  (alloc_vec),
    .ready_vec (ready_vec),
    .oldest_oh (sel_oh)
  );
`else
  assign sel_oh = ready_vec & (~ready_vec + NUM_ENTRIES'(1));
`endif

  assign sel_valid = |ready_vec;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_oh[i]) sel_idx = ENTRY_IDX_W'(i);
    end
  end

  assign sel_entry = sel_valid ? ent_vec[sel_idx] : '0;

  assign rs.prf_rd_en_rs0    = sel_valid;
  assign rs.prf_rd_psrc1_rs0 = src_is_reg(sel_entry.uinstr.src1) ? sel_entry.psrc1 : '0;
  assign rs.prf_rd_psrc2_rs0 = src_is_reg(sel_entry.uinstr.src2) ? sel_entry.psrc2 : '0;

  assign rs1_valid_next = sel_valid & ~rs.nuke_rb1.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_valid_reg  <= 1'b0;
      rs1_uinstr_reg <= '0;
      rs1_robid_reg  <= '0;
      rs1_pdst_reg   <= '0;
    end else begin
      rs1_valid_reg  <= rs1_valid_next;
      rs1_uinstr_reg <= sel_entry.uinstr;
      rs1_robid_reg  <= sel_entry.robid;
      rs1_pdst_reg   <= sel_entry.pdst;
    end
  end

  // A uop already in RS1 is killed by a nuke arriving in its issue cycle
  assign rs.iss_ex0 = rs1_valid_reg & ~rs.nuke_rb1.valid;

  always_comb begin
    rs.iss_pkt_ex0          = '0;
    rs.iss_pkt_ex0.uinstr   = rs1_uinstr_reg;
    rs.iss_pkt_ex0.robid    = rs1_robid_reg;
    rs.iss_pkt_ex0.pdst     = rs1_pdst_reg;
    rs.iss_pkt_ex0.src1_val = (rs1_valid_reg && src_is_reg(rs1_uinstr_reg.src1)) ?
                              rs.prf_rd_data1_rs1 : '0;
    rs.iss_pkt_ex0.src2_val = (rs1_valid_reg && src_is_reg(rs1_uinstr_reg.src2)) ?
                              rs.prf_rd_data2_rs1 : '0;
  end

  logic unused_ok;
  assign unused_ok = ^{rs.nuke_rb1.robid, rs.iprf_wr_pkt_ex1.data,
                       sel_entry.valid, sel_entry.rdy1, sel_entry.rdy2};

  assert property (@(posedge clk) disable iff (reset) !(rs.disp_valid_rs0 && rs.rs_full_rs0));

endmodule

// File: tb/tb_rs_int.sv
// Randomized and directed bench for rs_int against a slot/sequence-number reference model.
module tb_rs_int;
  import rs_int_pkg::*;

  localparam int NE = RS_INT_NUM_ENTRIES;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rs_int_if bus();

  rs_int dut (
    .clk   (clk),
    .reset (reset),
    .rs    (bus)
  );

  // PRF model: one-cycle read latency behind the read strobe
  t_rv_reg_data prf_mem [64];
  t_prf_id rd1_q = '0;
  t_prf_id rd2_q = '0;
  always @(posedge clk) begin
    rd1_q <= bus.prf_rd_psrc1_rs0;
    rd2_q <= bus.prf_rd_psrc2_rs0;
  end
  assign bus.prf_rd_data1_rs1 = prf_mem[rd1_q];
  assign bus.prf_rd_data2_rs1 = prf_mem[rd2_q];

  typedef struct {
    bit           valid;
    t_rs_disp_pkt pkt;
    bit           rdy1;
    bit           rdy2;
    int           seq;
  } slot_t;

  slot_t        slots [NE];
  int           seq_ctr  = 0;
  bit           rs1_v    = 1'b0;
  t_rs_disp_pkt rs1_pkt  = '0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int n_valid();
    int n = 0;
    for (int i = 0; i < NE; i++) if (slots[i].valid) n++;
    return n;
  endfunction

  function automatic int pick();
    int best = -1;
    for (int i = 0; i < NE; i++) begin
      if (slots[i].valid && slots[i].rdy1 && slots[i].rdy2) begin
`ifdef RS_INT_AGE_SELECT_EN
        if (best < 0 || slots[i].seq < slots[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic t_iss_pkt exp_iss(t_rs_disp_pkt p);
    t_iss_pkt e;
    e.uinstr   = p.uinstr;
    e.robid    = p.robid;
    e.pdst     = p.pdst;
    e.src1_val = (p.uinstr.src1.optype == OP_REG) ? prf_mem[p.psrc1] : '0;
    e.src2_val = (p.uinstr.src2.optype == OP_REG) ? prf_mem[p.psrc2] : '0;
    return e;
  endfunction

  function automatic t_rs_disp_pkt rnd_pkt();
    t_rs_disp_pkt p;
    p.uinstr.opcode      = 7'($urandom);
    p.uinstr.src1.optype = t_optype'($urandom_range(0, 2));
    p.uinstr.src1.areg   = 5'($urandom);
    p.uinstr.src2.optype = t_optype'($urandom_range(0, 2));
    p.uinstr.src2.areg   = 5'($urandom);
    p.uinstr.imm         = 12'($urandom);
    p.robid              = 6'($urandom);
    p.pdst               = 6'($urandom);
    p.psrc1              = 6'($urandom_range(0, 15));
    p.psrc2              = 6'($urandom_range(0, 15));
    return p;
  endfunction

  function automatic t_rs_disp_pkt mk(t_optype o1, int p1, t_optype o2, int p2);
    t_rs_disp_pkt p = rnd_pkt();
    p.uinstr.src1.optype = o1;
    p.psrc1              = 6'(p1);
    p.uinstr.src2.optype = o2;
    p.psrc2              = 6'(p2);
    return p;
  endfunction

  // One clock: drive, compare outputs with the model, then advance the model past the edge
  task automatic step(bit dv, t_rs_disp_pkt dp, bit wv, int wp, bit nk);
    int      sel;
    int      slot;
    bit      full;
    t_prf_id wid;
    wid  = 6'(wp);
    full = (n_valid() == NE);
    if (full) dv = 1'b0;
    @(negedge clk);
    bus.disp_valid_rs0       = dv;
    bus.disp_pkt_rs0         = dp;
    bus.iprf_wr_en_ex1       = wv;
    bus.iprf_wr_pkt_ex1.pdst = wid;
    bus.iprf_wr_pkt_ex1.data = $urandom;
    bus.nuke_rb1.valid       = nk;
    bus.nuke_rb1.robid       = '0;
    #1;
    sel = pick();
    chk("rs_full", bus.rs_full_rs0, full);
    chk("prf_rd_en", bus.prf_rd_en_rs0, sel >= 0);
    if (sel >= 0) begin
      chk("psrc1", bus.prf_rd_psrc1_rs0,
          (slots[sel].pkt.uinstr.src1.optype == OP_REG) ? slots[sel].pkt.psrc1 : 6'd0);
      chk("psrc2", bus.prf_rd_psrc2_rs0,
          (slots[sel].pkt.uinstr.src2.optype == OP_REG) ? slots[sel].pkt.psrc2 : 6'd0);
    end
    chk("iss_ex0", bus.iss_ex0, rs1_v && !nk);
    if (rs1_v && !nk) begin
      chk("iss_pkt", bus.iss_pkt_ex0, exp_iss(rs1_pkt));
      $display("ISSUE    robid=%0d pdst=%0d src1=%0h src2=%0h t=%0t", bus.iss_pkt_ex0.robid,
               bus.iss_pkt_ex0.pdst, bus.iss_pkt_ex0.src1_val, bus.iss_pkt_ex0.src2_val, $time);
    end

    rs1_v = (sel >= 0) && !nk;
    if (sel >= 0) rs1_pkt = slots[sel].pkt;
    if (nk) begin
      for (int i = 0; i < NE; i++) slots[i].valid = 1'b0;
    end else begin
      slot = -1;
      for (int i = 0; i < NE; i++) if (!slots[i].valid && slot < 0) slot = i;
      if (wv) begin
        for (int i = 0; i < NE; i++) begin
          if (slots[i].valid && slots[i].pkt.uinstr.src1.optype == OP_REG &&
              slots[i].pkt.psrc1 == wid) slots[i].rdy1 = 1'b1;
          if (slots[i].valid && slots[i].pkt.uinstr.src2.optype == OP_REG &&
              slots[i].pkt.psrc2 == wid) slots[i].rdy2 = 1'b1;
        end
      end
      if (sel >= 0) slots[sel].valid = 1'b0;
      if (dv) begin
        slots[slot].valid = 1'b1;
        slots[slot].pkt   = dp;
        slots[slot].rdy1  = (dp.uinstr.src1.optype != OP_REG) || (wv && dp.psrc1 == wid);
        slots[slot].rdy2  = (dp.uinstr.src2.optype != OP_REG) || (wv && dp.psrc2 == wid);
        slots[slot].seq   = seq_ctr;
        seq_ctr++;
        $display("DISPATCH robid=%0d slot=%0d t=%0t", dp.robid, slot, $time);
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic drive_idle();
    bus.disp_valid_rs0  = 1'b0;
    bus.disp_pkt_rs0    = '0;
    bus.iprf_wr_en_ex1  = 1'b0;
    bus.iprf_wr_pkt_ex1 = '0;
    bus.nuke_rb1        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_full", bus.rs_full_rs0, 1'b0);
    chk("rst_rd_en", bus.prf_rd_en_rs0, 1'b0);
    chk("rst_iss", bus.iss_ex0, 1'b0);
    chk("rst_pkt", bus.iss_pkt_ex0, '0);
    for (int i = 0; i < NE; i++) slots[i].valid = 1'b0;
    rs1_v = 1'b0;
    reset = 1'b0;
    $display("RESET    t=%0t", $time);
  endtask

  task automatic random_run(int n);
    for (int c = 0; c < n; c++) begin
      step($urandom_range(0, 99) < 60, rnd_pkt(), $urandom_range(0, 99) < 40,
           $urandom_range(0, 15), $urandom_range(0, 99) < 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prf_mem[i] = $urandom | 32'h1;
    drive_idle();
    do_reset();

    // Independent ADDI, source woken in the dispatch cycle
    step(1'b1, mk(OP_REG, 9, OP_IMM, 0), 1'b1, 9, 1'b0);
    idle(3);
    // ADD waiting on p12, then same-cycle wake of p7 on arrival
    step(1'b1, mk(OP_REG, 10, OP_REG, 12), 1'b1, 10, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b1, 12, 1'b0);
    idle(3);
    step(1'b1, mk(OP_REG, 7, OP_ZERO, 0), 1'b1, 7, 1'b0);
    idle(3);

    // Fill every entry waiting on p3, then drain
    for (int i = 0; i < NE; i++) step(1'b1, mk(OP_REG, 3, OP_IMM, 0), 1'b0, 0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 3, 1'b0);
    idle(NE + 2);

    // A lands in slot 2, B in slot 0, both on p4
    step(1'b1, mk(OP_REG, 5, OP_IMM, 0), 1'b0, 0, 1'b0);
    step(1'b1, mk(OP_REG, 6, OP_ZERO, 0), 1'b0, 0, 1'b0);
    step(1'b1, mk(OP_REG, 4, OP_IMM, 0), 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 5, 1'b0);
    step(1'b0, '0, 1'b1, 6, 1'b0);
    idle(3);
    step(1'b1, mk(OP_IMM, 0, OP_REG, 4), 1'b0, 0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b1, 4, 1'b0);
    idle(4);

    // Nuke in the select cycle with four entries valid
    for (int i = 0; i < 4; i++) step(1'b1, mk(OP_REG, 30, OP_IMM, 0), 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 30, 1'b0);
    step(1'b1, mk(OP_IMM, 0, OP_IMM, 0), 1'b0, 0, 1'b1);
    idle(3);
    step(1'b1, mk(OP_REG, 11, OP_IMM, 0), 1'b1, 11, 1'b0);
    idle(3);

    random_run(300);
    do_reset();
    random_run(200);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_int.md
Name: rs_int

Overview:
- Integer reservation station feeding the integer execute pipe.
- Buffers renamed uops from dispatch and tracks source readiness via PRF-write wakeups from execute.
- Selects one ready uop per cycle, reads its sources from the integer PRF, and drives iss_ex0 / iss_pkt_ex0 to execute one cycle after select.
- Sits between rename/dispatch and exe; producer side of the issue interface.

Parameters:
- NUM_ENTRIES, 8, number of RS entries (power of 2, >=2)
- ENTRY_IDX_W, $clog2(NUM_ENTRIES), entry index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- nuke_rb1  in  t_nuke_pkt  pipeline flush; .valid flushes all entries and in-flight issue
- disp_valid_rs0  in  1  dispatch request
- disp_pkt_rs0  in  t_rs_disp_pkt  uinstr, robid, pdst, psrc1, psrc2
- rs_full_rs0  out  1  no free entry; dispatch must not be attempted
- iprf_wr_en_ex1  in  1  execute PRF write (wakeup source)
- iprf_wr_pkt_ex1  in  t_prf_wr_pkt  .pdst used for wakeup match
- prf_rd_en_rs0  out  1  PRF read strobe for selected uop
- prf_rd_psrc1_rs0  out  t_prf_id  source 1 physical register
- prf_rd_psrc2_rs0  out  t_prf_id  source 2 physical register
- prf_rd_data1_rs1  in  t_rv_reg_data  read data, one cycle after strobe
- prf_rd_data2_rs1  in  t_rv_reg_data  read data, one cycle after strobe
- iss_ex0  out  1  issue valid to execute
- iss_pkt_ex0  out  t_iss_pkt  uinstr, robid, pdst, src1_val, src2_val

Behaviour:
- Reset: all entries invalid; rs_full_rs0=0, prf_rd_en_rs0=0, iss_ex0=0, iss_pkt_ex0='0.
- Entry state: valid, uinstr, robid, pdst, psrc1/2, rdy1/rdy2, age row.
- Dispatch:
  - When disp_valid_rs0 & !rs_full_rs0, write the lowest-index free entry at the clock edge.
  - rdyN=1 when srcN.optype != OP_REG, or when the psrcN match is the same-cycle iprf_wr_pkt_ex1.pdst with iprf_wr_en_ex1.
  - Otherwise rdyN=0.
- rs_full_rs0:
  - Combinational from the registered occupancy: 1 iff all entries are valid.
  - Dispatch while full is illegal (assertion); the entry array is unchanged.
- Wakeup: each cycle iprf_wr_en_ex1 sets rdyN on every valid entry whose psrcN == iprf_wr_pkt_ex1.pdst and srcN is OP_REG.
- Select (RS0):
  - Candidates are valid & rdy1 & rdy2 entries; at most one is chosen.
  - On select, prf_rd_en_rs0=1 and the psrcs are driven (zero for non-REG sources).
  - The entry is freed at the clock edge and can be re-dispatched the next cycle.
- Select priority: see Optional Feature.
- Issue (RS1 = EX0):
  - Selected entry fields are registered; iss_ex0 = registered select valid.
  - src1_val/src2_val = PRF read data for REG sources, '0 otherwise.
  - Exe substitutes the immediate.
- Latency:
  - Dispatch at T, all sources ready: earliest select T+1, iss_ex0 at T+2.
  - Wakeup at T: earliest select T+1 (PRF already holds the data), iss_ex0 at T+2.
- Nuke (nuke_rb1.valid):
  - All entries are invalidated at the edge.
  - A select in the same cycle is squashed: iss_ex0=0 next cycle.
  - A uop registered for RS1 in the previous cycle is also suppressed: iss_ex0 is gated by !nuke_rb1.valid.
  - A dispatch in the nuke cycle is dropped.
- Simultaneous dispatch + select + free in one cycle are all legal. A selected entry may not be re-allocated in the same cycle: the free vector comes from registered state.
- Reset mid-operation clears everything, including the RS1 stage.

Optional Feature:
- Macro: RS_INT_AGE_SELECT_EN.
- Defined: an NUM_ENTRIES x NUM_ENTRIES age matrix is kept. On dispatch, the new entry is marked younger than all valid entries. Select picks the oldest ready entry.
- Undefined: no age matrix; select picks the lowest-index ready entry (find-first).
- Interface is identical in both cases.

Decomposition:
- Shared package rob_defs or a new rs_defs.pkg holds:
  - t_rs_disp_pkt (t_uinstr uinstr, t_rob_id robid, t_prf_id pdst, psrc1, psrc2)
  - t_rs_entry
  - RS_INT_NUM_ENTRIES
- One sub-module, rs_age_matrix: dispatch vector and ready vector in, one-hot oldest-ready out. Instantiated only under RS_INT_AGE_SELECT_EN.

Test Plan:
- Independent ADDI dispatched cycle 0 (src1 ready) -> prf_rd_en_rs0 cycle 1, iss_ex0 cycle 2 with robid/pdst matching and src1_val = PRF data.
- ADD with psrc2=p12 not ready; iprf write pdst=p12 at cycle 5 -> select cycle 6, iss_ex0 cycle 7.
- Dispatch with psrc1=p7 in the same cycle as an iprf write to p7 -> entry ready on arrival; issues 2 cycles later.
- Fill 8 entries all waiting on p3 -> rs_full_rs0=1. Wake p3 -> one issue per cycle for 8 cycles; rs_full_rs0 deasserts the cycle after the first select.
- With AGE_SELECT_EN, dispatch A into idx2, B into idx0, both waiting on p4, then wake p4 -> A issues before B. Without the macro -> B first.
- nuke_rb1.valid asserted on the cycle a uop is selected while 4 entries are valid -> iss_ex0 stays 0; no further issues; rs_full_rs0=0; next dispatch lands in idx0.
